dvp_frame_capture: RTL and testbench



---
 rtl/dvp_frame_capture_pkg.sv | 28 ++
 rtl/dvp_frame_capture_edge.sv | 28 ++
 rtl/dvp_frame_capture.sv | 132 +++++++++++++
 tb/tb_dvp_frame_capture.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dvp_frame_capture_pkg.sv
// Shared definitions for the DVP frame capture block: geometry defaults, FSM states, pixel packing.
// Byte order inside a pixel follows CAPTURE_BYTE_SWAP_EN (undefined: first byte in the upper half).
package dvp_frame_capture_pkg;

   localparam int COL_PIX_DEF = 640;
   localparam int ROW_PIX_DEF = 480;

   localparam int RGB_R_W = 5;
   localparam int RGB_G_W = 6;
   localparam int RGB_B_W = 5;
   localparam int PIX_W   = RGB_R_W + RGB_G_W + RGB_B_W;
   localparam int BYTE_W  = PIX_W / 2;

   typedef enum logic {
      ST_IDLE    = 1'b0,
      ST_CAPTURE = 1'b1
   } cap_state_e;

   function automatic logic [PIX_W-1:0] pack_pix(input logic [BYTE_W-1:0] first_b,
                                                 input logic [BYTE_W-1:0] second_b);
`ifdef CAPTURE_BYTE_SWAP_EN
      return {second_b, first_b};
`else
      return {first_b, second_b};
`endif
   endfunction

endpackage

// File: rtl/dvp_frame_capture_edge.sv
// Input register with a previous-value stage; flags the selected edge of the registered copy.
module dvp_edge_det #(
   parameter bit RISING = 1'b1
) (
   input  logic clk,
   input  logic rst,
   input  logic sig_i,
   output logic level_o,
   output logic edge_o
);

   logic sig_q;
   logic prev_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sig_q  <= 1'b0;
         prev_q <= 1'b0;
      end else begin
         sig_q  <= sig_i;
         prev_q <= sig_q;
      end
   end

   assign level_o = sig_q;
   assign edge_o  = RISING ? (sig_q & ~prev_q) : (~sig_q & prev_q);

endmodule

// File: rtl/dvp_frame_capture.sv
// Captures one DVP frame and packs byte pairs into 16-bit pixels with sop/eop framing.
// Build option: CAPTURE_BYTE_SWAP_EN swaps the byte order of each packed pixel.
//
// state      | meaning
// -----------+----------------------------------------------------------
// ST_IDLE    | waiting for a vsync rising edge with en_capture high
// ST_CAPTURE | counting bytes/lines of the frame, emitting pixels to eop
module dvp_frame_capture
   import dvp_frame_capture_pkg::*;
#(
   parameter int COL_PIX = COL_PIX_DEF,
   parameter int ROW_PIX = ROW_PIX_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en_capture,
   input  logic              vsync,
   input  logic              href,
   input  logic [BYTE_W-1:0] din,
   output logic [PIX_W-1:0]  dout,
   output logic              dout_vld,
   output logic              dout_sop,
   output logic              dout_eop
);

   localparam int BCW   = $clog2(2 * COL_PIX + 1);
   localparam int COL_W = BCW - 1;
   localparam int RW    = (ROW_PIX > 1) ? $clog2(ROW_PIX) : 1;

   localparam logic [BCW-1:0]   BYTES_LINE = BCW'(2 * COL_PIX);
   localparam logic [BCW-1:0]   BYTES_PIX  = BCW'(2);
   localparam logic [COL_W-1:0] COL_LAST   = COL_W'(COL_PIX - 1);
   localparam logic [RW-1:0]    ROW_LAST   = RW'(ROW_PIX - 1);

   logic vsync_lvl, vsync_rise;
   logic href_q, href_fall;

   cap_state_e        state_q;
   logic [BYTE_W-1:0] din_q;
   logic [BYTE_W-1:0] first_byte_q;
   logic [BCW-1:0]    byte_cnt_q;
   logic [RW-1:0]     row_q;
   logic              rows_done_q;
   logic [PIX_W-1:0]  dout_q;
   logic              vld_q, sop_q, eop_q;

   logic              in_line, pix_fire, sop_d, eop_d;
   logic [COL_W-1:0]  col_cur;

   dvp_edge_det #(.RISING(1'b1)) u_vsync_edge (
      .clk     (clk),
      .rst     (rst),
      .sig_i   (vsync),
      .level_o (vsync_lvl),
      .edge_o  (vsync_rise)
   );

   dvp_edge_det #(.RISING(1'b0)) u_href_edge (
      .clk     (clk),
      .rst     (rst),
      .sig_i   (href),
      .level_o (href_q),
      .edge_o  (href_fall)
   );

   // Column is the pair index of the byte counter, so it restarts with every line.
   always_comb begin
      in_line  = (state_q == ST_CAPTURE) && href_q && !rows_done_q && (byte_cnt_q < BYTES_LINE);
      pix_fire = in_line && byte_cnt_q[0];
      col_cur  = byte_cnt_q[BCW-1:1];
      sop_d    = pix_fire && (col_cur == '0) && (row_q == '0);
      eop_d    = pix_fire && (col_cur == COL_LAST) && (row_q == ROW_LAST);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         din_q        <= '0;
         first_byte_q <= '0;
         byte_cnt_q   <= '0;
         row_q        <= '0;
         rows_done_q  <= 1'b0;
         dout_q       <= '0;
         vld_q        <= 1'b0;
         sop_q        <= 1'b0;
         eop_q        <= 1'b0;
      end else begin
         din_q <= din;
         vld_q <= 1'b0;
         sop_q <= 1'b0;
         eop_q <= 1'b0;
         if (vsync_rise && vsync_lvl) begin
            state_q     <= en_capture ? ST_CAPTURE : ST_IDLE;
            byte_cnt_q  <= '0;
            row_q       <= '0;
            rows_done_q <= 1'b0;
         end else if (state_q == ST_CAPTURE) begin
            if (pix_fire) begin
               dout_q <= pack_pix(first_byte_q, din_q);
               vld_q  <= 1'b1;
               sop_q  <= sop_d;
               eop_q  <= eop_d;
            end
            if (eop_d) begin
               state_q    <= ST_IDLE;
               byte_cnt_q <= '0;
               row_q      <= '0;
            end else if (href_fall) begin
               byte_cnt_q <= '0;
               // A short final row wraps the row counter but blocks any further lines.
               if (byte_cnt_q >= BYTES_PIX) begin
                  if (row_q == ROW_LAST) begin
                     row_q       <= '0;
                     rows_done_q <= 1'b1;
                  end else begin
                     row_q <= row_q + RW'(1);
                  end
               end
            end else if (in_line) begin
               if (!byte_cnt_q[0]) first_byte_q <= din_q;
               byte_cnt_q <= byte_cnt_q + BCW'(1);
            end
         end
      end
   end

   assign dout     = dout_q;
   assign dout_vld = vld_q;
   assign dout_sop = sop_q;
   assign dout_eop = eop_q;

endmodule

// File: tb/tb_dvp_frame_capture.sv
// Scoreboard bench for dvp_frame_capture on a reduced 8x4 geometry with randomized camera bytes.
module tb_dvp_frame_capture;

   localparam int COL = 8;
   localparam int ROW = 4;

   logic        clk = 1'b0;
   logic        rst, en_capture, vsync, href;
   logic [7:0]  din;
   logic [15:0] dout;
   logic        dout_vld, dout_sop, dout_eop;

   dvp_frame_capture #(.COL_PIX(COL), .ROW_PIX(ROW)) dut (
      .clk        (clk),
      .rst        (rst),
      .en_capture (en_capture),
      .vsync      (vsync),
      .href       (href),
      .din        (din),
      .dout       (dout),
      .dout_vld   (dout_vld),
      .dout_sop   (dout_sop),
      .dout_eop   (dout_eop)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [15:0] d;
      logic        sop;
      logic        eop;
      int          at;
   } exp_t;

   exp_t exp_q[$];
   int   n_checks = 0;
   int   n_pass   = 0;

   bit m_active = 1'b0;
   bit m_done   = 1'b0;
   int m_row    = 0;

   function automatic logic [15:0] pk(input logic [7:0] b0, input logic [7:0] b1);
`ifdef CAPTURE_BYTE_SWAP_EN
      return {b1, b0};
`else
      return {b0, b1};
`endif
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act === req) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
   endtask

   // Monitor: every pixel the DUT presents is matched against the oldest expectation.
   logic [15:0] last_dout = '0;
   logic        prev_vld  = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         last_dout = '0;
         prev_vld  = 1'b0;
      end else begin
         check("sop_eop_without_vld", 32'({dout_sop, dout_eop} & {2{~dout_vld}}), 0);
         if (dout_vld) begin
            check("vld_back_to_back", 32'(prev_vld), 0);
            if (exp_q.size() == 0) begin
               n_checks++;
               $display("FAIL unexpected_pixel: got dout=%h sop=%b eop=%b, expected no pixel", dout, dout_sop, dout_eop);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("pixel_data", 32'(dout), 32'(e.d));
               check("pixel_sop", 32'(dout_sop), 32'(e.sop));
               check("pixel_eop", 32'(dout_eop), 32'(e.eop));
               check("pixel_latency", cyc, e.at);
            end
            last_dout = dout;
         end else begin
            check("dout_hold", 32'(dout), 32'(last_dout));
         end
         prev_vld = dout_vld;
      end
   end

   task automatic idle(input int n);
      href = 1'b0;
      repeat (n) @(negedge clk);
   endtask

   task automatic vs_pulse(input bit en);
      en_capture = en;
      vsync      = 1'b1;
      if (en) begin
         m_active = 1'b1;
         m_done   = 1'b0;
         m_row    = 0;
      end else begin
         m_active = 1'b0;
      end
      repeat (3) @(negedge clk);
      vsync = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   // mode 0: random bytes, 1: 1,2,3,..., 2: AB,CD then random
   task automatic line(input int len, input int mode);
      logic [7:0] prev_b, b;
      bit live, eop_seen;
      live     = m_active && !m_done;
      eop_seen = 1'b0;
      prev_b   = '0;
      for (int i = 0; i < len; i++) begin
         if (mode == 1) b = 8'(i + 1);
         else if (mode == 2 && i == 0) b = 8'hAB;
         else if (mode == 2 && i == 1) b = 8'hCD;
         else b = 8'($urandom);
         href = 1'b1;
         din  = b;
         if (live && i < 2 * COL && (i % 2) == 1) begin
            int   pix;
            exp_t e;
            pix   = i / 2;
            e.d   = pk(prev_b, b);
            e.sop = (m_row == 0) && (pix == 0);
            e.eop = (m_row == ROW - 1) && (pix == COL - 1);
            e.at  = cyc + 2;
            exp_q.push_back(e);
            if (e.eop) eop_seen = 1'b1;
         end
         prev_b = b;
         @(negedge clk);
      end
      href = 1'b0;
      din  = 8'($urandom);
      if (live && len >= 2) begin
         if (eop_seen) m_active = 1'b0;
         else begin
            m_row++;
            if (m_row == ROW) m_done = 1'b1;
         end
      end
      idle(3);
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; en_capture = 1'b1; vsync = 1'b0; href = 1'b0; din = '0;
      for (int i = 0; i < 3; i++) begin
         href = 1'($urandom);
         din  = 8'($urandom);
         @(negedge clk);
      end
      check("reset_dout", 32'(dout), 0);
      check("reset_vld", 32'(dout_vld), 0);
      check("reset_sop", 32'(dout_sop), 0);
      check("reset_eop", 32'(dout_eop), 0);
      href = 1'b0;
      rst  = 1'b0;
      for (int i = 0; i < 12; i++) begin
         href = 1'($urandom);
         din  = 8'($urandom);
         @(negedge clk);
      end
      idle(4);

      // sequential first line, full frame, then lines after eop are ignored
      vs_pulse(1'b1);
      line(2 * COL, 1);
      for (int r = 1; r < ROW; r++) line(2 * COL, 0);
      line(2 * COL, 0);
      line(2 * COL, 0);

      // capture disabled at frame start
      vs_pulse(1'b0);
      for (int r = 0; r < ROW; r++) line(2 * COL, 0);

      // enable drops mid-frame, frame still completes
      vs_pulse(1'b1);
      line(2 * COL, 2);
      line(2 * COL, 0);
      en_capture = 1'b0;
      line(2 * COL, 0);
      line(2 * COL, 0);

      // over-long line, 3-byte line with dangling byte
      vs_pulse(1'b1);
      line(2 * COL + 1, 0);
      line(3, 1);
      line(2 * COL, 1);
      line(2 * COL, 0);
      line(2 * COL, 0);

      // restart mid-frame with enable high, then abort with enable low
      vs_pulse(1'b1);
      line(2 * COL, 0);
      line(2 * COL, 0);
      vs_pulse(1'b1);
      for (int r = 0; r < ROW; r++) line(2 * COL, 0);
      vs_pulse(1'b1);
      line(2 * COL, 0);
      vs_pulse(1'b0);
      line(2 * COL, 0);
      line(2 * COL, 0);

      // randomized frames with random line lengths, including short last rows
      for (int f = 0; f < 8; f++) begin
         int nl;
         vs_pulse(1'($urandom_range(0, 3) != 0));
         nl = $urandom_range(1, ROW + 2);
         for (int r = 0; r < nl; r++) line($urandom_range(1, 2 * COL + 4), 0);
      end

      idle(10);
      check("queue_drained", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
